// File: rtl/hidden_cpu_pkg.sv
// Shared types and constants for the hidden_cpu core and its ALU.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hidden_cpu_pkg;

  // Instruction opcodes, instr[2:0].
  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_XOR = 3'd3,
    OP_MOV = 3'd4,
    OP_LDI = 3'd5,
    OP_BR  = 3'd6,
    OP_SEL = 3'd7
  } opcode_e;

  // Branch condition codes carried in the rd field of a BR.
  // Any code at or above COND_LAST+1 is never taken.
  localparam int COND_ALWAYS = 0;
  localparam int COND_C      = 1;
  localparam int COND_B      = 2;
  localparam int COND_Z      = 3;

  // Sequencer states. The register holding the state is a plain logic
  // vector compared against these constants.
  localparam logic [0:0] ST_EXEC = 1'b0;
  localparam logic [0:0] ST_IMM  = 1'b1;

  typedef enum logic [0:0] {
    EXEC = ST_EXEC,
    IMM  = ST_IMM
  } state_e;

  // Flag register layout: flags = {Z, B, C}.
  localparam int NFLAGS = 3;
  localparam int FLAG_C = 0;
  localparam int FLAG_B = 1;
  localparam int FLAG_Z = 2;

endpackage

// File: rtl/hidden_cpu_if.sv
// Pin-side bundle of the core: instruction word in, display/status out.
// Latency: n/a (wiring only).
// Backpressure: none; every valid word is taken on the edge it is presented.
interface hidden_cpu_if
  import hidden_cpu_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int INSTR_W = 8
);

  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic [DATA_W-1:0]  out;
  logic               imm_pending;
  logic [NFLAGS-1:0]  flags;

  // Driver side: the input pins feeding the core.
  modport master (
    output instr,
    output instr_valid,
    input  out,
    input  imm_pending,
    input  flags
  );

  // Core side.
  modport slave (
    input  instr,
    input  instr_valid,
    output out,
    output imm_pending,
    output flags
  );

endinterface

// File: rtl/hidden_cpu_alu.sv
// Combinational ALU: result, next flag value and register write-enable per opcode.
// Latency: 0 cycles (pure combinational).
// Backpressure: n/a; the core decides whether the result is committed.
module hidden_alu
  import hidden_cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  opcode_e           opcode,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [NFLAGS-1:0] flags_in,
  output logic [DATA_W-1:0] result,
  output logic [NFLAGS-1:0] flags_out,
  output logic              we
);

  // One extra bit holds carry-out for ADD and the borrow for SUB.
  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  // Opcode decode; flags not touched by an opcode keep their old value.
  always_comb begin
    result    = a;
    flags_out = flags_in;
    we        = 1'b0;
    case (opcode)
      OP_ADD: begin
        result            = sum[DATA_W-1:0];
        flags_out[FLAG_C] = sum[DATA_W];
        flags_out[FLAG_Z] = (sum[DATA_W-1:0] == '0);
        we                = 1'b1;
      end
      OP_SUB: begin
        // The borrow out of the widened subtract is exactly a < b unsigned.
        result            = diff[DATA_W-1:0];
        flags_out[FLAG_B] = diff[DATA_W];
        flags_out[FLAG_Z] = (diff[DATA_W-1:0] == '0);
        we                = 1'b1;
      end
      OP_AND: begin
        result            = a & b;
        flags_out[FLAG_Z] = ((a & b) == '0);
        we                = 1'b1;
      end
      OP_XOR: begin
        result            = a ^ b;
        flags_out[FLAG_Z] = ((a ^ b) == '0);
        we                = 1'b1;
      end
      OP_MOV: begin
        result = b;
        we     = 1'b1;
      end
      default: begin
        // LDI, BR and SEL never write a register from the ALU.
        result = a;
        we     = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/hidden_cpu_core.sv
// Parametrised pin-driven core: register file, flags, pc, LDI sequencer, output mux.
// Latency: a word accepted at edge N is reflected on out/flags right after edge N.
// Backpressure: none; instr is consumed on every edge where instr_valid is high.
module hidden_cpu_core
  import hidden_cpu_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int NREGS   = 4,
  parameter int PC_W    = 8,
  parameter int INSTR_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  hidden_cpu_if.slave  bus
);

  localparam int RA_W = $clog2(NREGS);

  // Architectural state.
  logic [DATA_W-1:0] rf [NREGS];
  logic [PC_W-1:0]   pc;
  logic [NFLAGS-1:0] flags_q;
  logic              sel_out;
  logic [0:0]        state;
  logic [RA_W-1:0]   ld_rd;

  // Instruction fields; bits above the rs field are ignored.
  opcode_e         opcode;
  logic [RA_W-1:0] rd;
  logic [RA_W-1:0] rs;

  assign opcode = opcode_e'(bus.instr[2:0]);
  assign rd     = bus.instr[3 +: RA_W];
  assign rs     = bus.instr[3+RA_W +: RA_W];

  // Both operands come from the current register contents, so rd==rs
  // reads the pre-write value.
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;

  assign op_a = rf[rd];
  assign op_b = rf[rs];

  // A word is either an instruction (EXEC) or the LDI payload (IMM).
  logic exec_fire;
  logic imm_fire;

  assign exec_fire = bus.instr_valid && (state == ST_EXEC);
  assign imm_fire  = bus.instr_valid && (state == ST_IMM);

  logic [DATA_W-1:0] alu_result;
  logic [NFLAGS-1:0] alu_flags;
  logic              alu_we;

  hidden_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .opcode    (opcode),
    .a         (op_a),
    .b         (op_b),
    .flags_in  (flags_q),
    .result    (alu_result),
    .flags_out (alu_flags),
    .we        (alu_we)
  );

  // Branch condition: the rd field selects which flag gates the branch.
  logic br_taken;

  always_comb begin
    br_taken = 1'b0;
    case (int'(rd))
      COND_ALWAYS: br_taken = 1'b1;
      COND_C:      br_taken = flags_q[FLAG_C];
      COND_B:      br_taken = flags_q[FLAG_B];
      COND_Z:      br_taken = flags_q[FLAG_Z];
      default:     br_taken = 1'b0;
    endcase
  end

  // Next pc for an executed instruction; both paths wrap modulo 2^PC_W.
  // A taken branch through a zero register yields pc itself, a legal spin.
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] pc_next;

  always_comb begin
    pc_inc  = pc + PC_W'(1);
    pc_next = pc_inc;
    if ((opcode == OP_BR) && br_taken) begin
      pc_next = pc + op_b[PC_W-1:0];
    end
  end

  // Program counter: every accepted word moves it; branches redirect it.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= '0;
    end else if (imm_fire) begin
      pc <= pc_inc;
    end else if (exec_fire) begin
      pc <= pc_next;
    end
  end

  // LDI sequencer: remember the destination, then treat the next
  // accepted word as data. Reset drops any pending load.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_EXEC;
      ld_rd <= '0;
    end else if (exec_fire && (opcode == OP_LDI)) begin
      state <= ST_IMM;
      ld_rd <= rd;
    end else if (imm_fire) begin
      state <= ST_EXEC;
    end
  end

  // Flags follow the ALU on every executed instruction; the ALU hands
  // back the old value for opcodes that do not affect them.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= '0;
    end else if (exec_fire) begin
      flags_q <= alu_flags;
    end
  end

  // Output select toggles on SEL.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_out <= 1'b0;
    end else if (exec_fire && (opcode == OP_SEL)) begin
      sel_out <= ~sel_out;
    end
  end

  // Register file: reset to r[i]=i, single-register write-back otherwise.
  // The LDI payload is zero-extended or truncated to the register width.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        rf[i] <= DATA_W'(i);
      end
    end else if (imm_fire) begin
      rf[ld_rd] <= DATA_W'(bus.instr);
    end else if (exec_fire && alu_we) begin
      rf[rd] <= alu_result;
    end
  end

  // Outputs are decoded from state registers only.
  assign bus.out         = sel_out ? rf[NREGS-1] : DATA_W'(pc);
  assign bus.imm_pending = (state == ST_IMM);
  assign bus.flags       = flags_q;

endmodule

// File: doc/hidden_cpu_core.md
# hidden_cpu_core

Parametrised successor to the pin-driven 8-bit core. Width, register count and PC width are parameters. Instructions are accepted under a valid qualifier. Adds:
- true single-register write-back
- a persistent flag register (C/B/Z)
- conditional relative branches
- a two-word load-immediate handled by a small state machine

The block sits between the chip's input pins and the output pins. `out` shows either the PC or the top register.

## Interface
Parameters:
- `DATA_W`, 8: register/ALU width (≥4)
- `NREGS`, 4: register count, power of two, ≥4; `RA_W = log2(NREGS)`
- `PC_W`, 8: program-counter width, `PC_W ≤ DATA_W`
- `INSTR_W`, 8: instruction bus width, `≥ 3 + 2*RA_W`

Ports:
- `clk`, in, 1: single clock, rising edge
- `rst`, in, 1: synchronous, active-high reset
- `instr`, in, `INSTR_W`: instruction or immediate word
- `instr_valid`, in, 1: `instr` is consumed on this edge
- `out`, out, `DATA_W`: `sel_out ? r[NREGS-1] : zero-extended pc`
- `imm_pending`, out, 1: high while in state IMM
- `flags`, out, 3: {Z, B, C}

## Operation
- Instruction fields:
  - opcode = `instr[2:0]`
  - rd = `instr[3 +: RA_W]`
  - rs = `instr[3+RA_W +: RA_W]`
  - upper bits ignored
- Opcodes and flag effects:
  - 0 ADD: `rd=rd+rs`; C=carry-out, Z
  - 1 SUB: `rd=rd-rs`; B=(rd<rs) unsigned, Z
  - 2 AND: Z
  - 3 XOR: Z
  - 4 MOV: `rd=rs`, flags unchanged
  - 5 LDI: enter IMM
  - 6 BR
  - 7 SEL: toggle `sel_out`
- Flag updates:
  - ADD leaves B unchanged; SUB leaves C unchanged.
  - Z = (result==0).
- BR: the rd field is the condition code: 0 always, 1 C, 2 B, 3 Z; codes ≥4 are never taken.
  - Taken: `pc = pc + r[rs][PC_W-1:0]`, mod `2^PC_W`.
  - Not taken: `pc+1`.
- All other opcodes advance `pc+1`, also mod `2^PC_W`.
- Write-back touches only `r[rd]`. All other registers hold their value.
- State machine:
  - EXEC, valid & LDI: latch rd into `ld_rd`, pc+1, go to IMM.
  - IMM, valid: `r[ld_rd] = instr` zero-extended or truncated to `DATA_W`; pc+1; flags unchanged; return to EXEC. The word is never decoded as an opcode.
  - Either state, `instr_valid=0`: no state change at all.
- Reset values:
  - pc=0, `r[i]=i` (mod `2^DATA_W`), flags=0, `sel_out=0`
  - state=EXEC, `out=0`, `imm_pending=0`
- Boundary behaviour:
  - rst together with `instr_valid`: rst wins and the word is dropped.
  - rst during IMM: return to EXEC; the pending load is lost.
  - rd==rs: operands are read before write, so SUB rd,rd gives 0, Z=1, B=0.
  - BR with rs pointing to a register holding 0: pc holds; this is a legal spin.
  - PC wraps at `2^PC_W-1` to 0.

## Timing
- One accepted word per cycle. No stall or back-pressure output.
- Register, flag, pc and `sel_out` updates from a word accepted at edge N are visible on `out`/`flags` after edge N.
- Output is registered-source combinational: `out` and `flags` are mux/decode of state registers only. There is no combinational path from `instr`.
- LDI takes two accepted words. `imm_pending` is high for exactly the cycles between them.
- Branch target uses `r[rs]` and pc as they stand before edge N.

## Structure
- Package `hidden_cpu_pkg`:
  - opcode enum (ADD…SEL)
  - branch condition codes
  - state enum {EXEC, IMM}
  - flag bit indices
- Sub-module `hidden_alu` (combinational, parametrised by `DATA_W`):
  - inputs: opcode, a, b, old flags
  - outputs: result, new flags, write-enable
- The core holds the register file, pc, state, `sel_out`, branch resolution and output mux.

## Test plan
1. Reset: rst high 2 cycles with `instr_valid=1` → `out`=0x00, r0..r3=0,1,2,3, flags=000, `imm_pending`=0; no instruction executed.
2. ADD r1,r3 (r1=1, r3=3) → r1=4, pc=1, C=0. Then LDI r2 + 0xFF, then ADD r2,r3 → r2=0x02, C=1, Z=0, pc=4; r0/r3 unchanged.
3. SUB r0,r1 with r0=0, r1=1 → r0=0xFF, B=1. Then BR cond=2 rs=r3(3) from pc=1 → pc=4. Then BR cond=3 (Z=0) → pc=5.
4. LDI r3 then `instr_valid=0` for 3 cycles (`imm_pending` stays 1, pc frozen), then 0xA5 → r3=0xA5. Then SEL → `out`=0xA5. Then SEL → `out`=pc.
5. LDI r1, then rst asserted during IMM → state EXEC, r1=1, pc=0. The next word 0x05 decodes as LDI (opcode 5), not as data.
6. PC wrap: set pc=0xFE via a BR with r3=0xFE, then two ADDs → pc=0xFF, then 0x00. BR with r[rs]=0 holds pc for 3 cycles.
